// File: rtl/gemm_feeder.sv
// Edge driver for the GEMM systolic array: buffers one A and one B tile from a
// valid/ready load stream, then emits them as skewed lane streams and a drain pulse.
module gemm_feeder #(
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_DIM         = 4,
  parameter int C_DRAIN_DELAY = 4
) (
  input  logic                            clock,
  input  logic                            i_reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [C_DATA_WIDTH-1:0]         in_data,
  output logic [C_DIM*C_DATA_WIDTH-1:0]   Aout_data,
  output logic [C_DIM-1:0]                Aout_valid,
  output logic [C_DIM*C_DATA_WIDTH-1:0]   Bout_data,
  output logic [C_DIM-1:0]                Bout_valid,
  output logic                            o_rd_output,
  output logic                            o_busy
);

  localparam int NUM_ELEMS = 2 * C_DIM * C_DIM;
  localparam int A_ELEMS   = C_DIM * C_DIM;
  localparam int N_W       = ($clog2(NUM_ELEMS) > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int T_W       = ($clog2(2 * C_DIM) > 1) ? $clog2(2 * C_DIM) : 1;
  localparam int W_W       = ($clog2(C_DRAIN_DELAY) > 1) ? $clog2(C_DRAIN_DELAY) : 1;

  localparam logic [N_W-1:0] N_LAST = N_W'(NUM_ELEMS - 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(2 * C_DIM - 2);
  localparam logic [W_W-1:0] W_LAST = W_W'((C_DRAIN_DELAY > 0) ? C_DRAIN_DELAY - 1 : 0);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_STREAM,
    ST_WAIT,
    ST_RDOUT
  } state_e;

  state_e                  state_q, state_d;
  logic [N_W-1:0]          n_q, n_d;
  logic [T_W-1:0]          t_q, t_d;
  logic [W_W-1:0]          w_q, w_d;
  logic                    in_ready_q, in_ready_d;
  logic [C_DATA_WIDTH-1:0] tile_q [NUM_ELEMS];
  logic [C_DATA_WIDTH-1:0] tile_d [NUM_ELEMS];

  // Flat tile store: A row-major in [0, D*D), B row-major in [D*D, 2*D*D).
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    t_d        = t_q;
    w_d        = w_q;
    tile_d     = tile_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          tile_d[n_q] = in_data;
          if (n_q == N_LAST) begin
            n_d     = '0;
            t_d     = '0;
            state_d = ST_STREAM;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (t_q == T_LAST) begin
          t_d     = '0;
          state_d = (C_DRAIN_DELAY > 0) ? ST_WAIT : ST_RDOUT;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_q == W_LAST) begin
          w_d     = '0;
          state_d = ST_RDOUT;
        end else begin
          w_d = w_q + 1'b1;
        end
      end
      ST_RDOUT: state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
    in_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_LOAD;
      n_q        <= '0;
      t_q        <= '0;
      w_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      t_q        <= t_d;
      w_q        <= w_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Tile storage carries no reset; the outputs are gated by state so stale data never leaks.
  always_ff @(posedge clock) begin
    tile_q <= tile_d;
  end

  always_comb begin
    Aout_data  = '0;
    Aout_valid = '0;
    Bout_data  = '0;
    Bout_valid = '0;
    if (state_q == ST_STREAM) begin
      for (int i = 0; i < C_DIM; i++) begin
        if (int'(t_q) >= i && int'(t_q) <= i + C_DIM - 1) begin
          Aout_valid[i] = 1'b1;
          Bout_valid[i] = 1'b1;
          Aout_data[i*C_DATA_WIDTH +: C_DATA_WIDTH] =
            tile_q[N_W'(i * C_DIM + int'(t_q) - i)];
          Bout_data[i*C_DATA_WIDTH +: C_DATA_WIDTH] =
            tile_q[N_W'(A_ELEMS + (int'(t_q) - i) * C_DIM + i)];
        end
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign o_rd_output = (state_q == ST_RDOUT);
  assign o_busy      = (state_q != ST_LOAD);

endmodule

// File: doc/gemm_feeder.md
# gemm_feeder

Edge driver for the GEMM systolic array. Accepts one C_DIM×C_DIM A tile and one C_DIM×C_DIM B tile over a valid/ready load stream and buffers both. It then emits them as skewed per-lane streams into the array's A (row) and B (column) edge inputs, and issues the `rd_output` pulse that starts the PE result drain. It is the transmitter side of the PE `Ain`/`Bin`/`rd_output` interface.

## Interface
- C_DATA_WIDTH, 32, element width.
- C_DIM, 4, array dimension (≥1); number of A lanes and B lanes.
- C_DRAIN_DELAY, 4, idle cycles between the last streamed element and the `o_rd_output` pulse (≥0); covers MAC and RAM latency in the array.
- clock  in  1  sole clock; all state on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  load element valid.
- in_ready  out  1  feeder accepts a load element.
- in_data  in  C_DATA_WIDTH  load element.
- Aout_data  out  C_DIM*C_DATA_WIDTH  lane i in bits [i*W +: W]; feeds array row i.
- Aout_valid  out  C_DIM  per-lane valid.
- Bout_data  out  C_DIM*C_DATA_WIDTH  lane j in bits [j*W +: W]; feeds array column j.
- Bout_valid  out  C_DIM  per-lane valid.
- o_rd_output  out  1  one-cycle drain request to the array.
- o_busy  out  1  high whenever state ≠ LOAD.

## Operation
- States: LOAD → STREAM → WAIT → RDOUT → LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) stores in_data at load index n, which counts 0..2·D²−1 (D=C_DIM).
  - n<D²: A[n/D][n%D] (row-major A[i][k]).
  - n≥D²: B[(n−D²)/D][(n−D²)%D] (row-major B[k][j]).
  - Handshake at n=2·D²−1 → STREAM, t=0, n cleared.
  - in_valid gaps are allowed; the index holds.
- STREAM: runs t=0..2D−2 (2D−1 cycles).
  - In the cycle where state=STREAM with counter t, Aout_valid[i]=1 iff i ≤ t ≤ i+D−1, with Aout lane i = A[i][t−i].
  - Bout_valid[j]=1 iff j ≤ t ≤ j+D−1, with Bout lane j = B[t−j][j].
  - Invalid lanes drive data 0.
  - At t=2D−2: → WAIT if C_DRAIN_DELAY>0, else → RDOUT.
- WAIT: counts C_DRAIN_DELAY cycles, all valids 0, then → RDOUT.
- RDOUT: o_rd_output=1 for exactly this one cycle, then → LOAD.
- in_ready=0 in every state except LOAD. Elements presented then are not consumed.
- Single tile buffer: the next tile loads only after RDOUT. Buffer contents persist but are overwritten by the next load.
- Counters sized $clog2(2·D²) and $clog2(2D), minimum 1 bit. No wrap occurs inside a state: each counter clears on state exit.

## Timing
- Reset (i_reset_n=0, asynchronous):
  - state=LOAD, counters 0.
  - in_ready=0 while asserted, 1 from the first clock edge after release.
  - All Aout/Bout data and valids 0; o_rd_output=0; o_busy=0.
- All outputs are registered or decoded directly from state registers, with no combinational path from in_valid or in_data.
- Load-to-stream latency: the first STREAM cycle, with Aout_valid[0] and Bout_valid[0], is the cycle immediately after the final load handshake.
- Stream length is 2D−1 cycles. Lane k is valid for exactly D consecutive cycles, starting at t=k.
- The o_rd_output pulse occurs 2D−1+C_DRAIN_DELAY cycles after the first STREAM cycle.
- RDOUT → LOAD: in_ready is high in the cycle after the pulse.
- Reset mid-operation, in any state:
  - Immediately clears valids and o_rd_output and aborts the tile.
  - A partial load is discarded, and the load index restarts at 0.
- D=1 boundary: 2 load elements, a 1-cycle STREAM with lane 0 valid, then WAIT/RDOUT as normal.

## Test plan
- D=4, C_DRAIN_DELAY=4, load A[i][k]=0x10·i+k, B[k][j]=0x100+0x10·k+j, with in_valid held continuously. Required response:
  - 32 handshakes.
  - STREAM t=0: Aout_valid=0001, lane0=0x00; Bout lane0=0x100.
  - t=3: Aout_valid=1111, Aout lane3=0x30, lane0=0x03; Bout lane2=0x112.
  - t=6: only lane3 valid, Aout=0x33, Bout=0x133.
  - o_rd_output at the 11th cycle after stream start.
- Same tile with random in_valid gaps (~50% duty). Required response: identical stream values, with the stream starting one cycle after the 32nd handshake.
- in_valid held high during STREAM, WAIT and RDOUT. Required response: in_ready=0 and no elements consumed; the next tile's first element loads to A[0][0] after RDOUT.
- C_DRAIN_DELAY=0. Required response: o_rd_output in the cycle after t=6, and in_ready=1 in the following cycle.
- Assert i_reset_n=0 mid-STREAM at t=3, between clock edges. Required response:
  - Valids and data drop to 0 without waiting for a clock edge.
  - After release, o_busy=0 and in_ready=1.
  - A fresh 32-element load streams correctly.
- D=1, C_DRAIN_DELAY=2, load A=0x5, B=0x7. Required response: one STREAM cycle with Aout=0x5 and Bout=0x7 both valid, then 2 idle cycles, then an o_rd_output pulse.
